// File: rtl/snake_pkg.sv
// Shared snake-game constants, coordinate types and placement FSM states.
package snake_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int XW     = 6;
    localparam int YW     = 5;
    localparam int LW     = 6;

    typedef logic [XW-1:0] coord_x_t;
    typedef logic [YW-1:0] coord_y_t;
    typedef logic [LW-1:0] idx_t;
    typedef logic [LW:0]   len_t;

    localparam coord_x_t X_LIM = XW'(GRID_W);
    localparam coord_y_t Y_LIM = YW'(GRID_H);

    // x^6+x^5+1 and x^5+x^3+1, both maximal length
    localparam coord_x_t TAPS_X = 6'b110000;
    localparam coord_y_t TAPS_Y = 5'b10100;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        SCAN,
        COMMIT,
        FAIL
    } state_t;

endpackage

// File: rtl/apple_place_ctrl_if.sv
// Apple placer bus: request/head inputs, body RAM read port and results.
interface apple_place_ctrl_if;
    import snake_pkg::*;

    logic     place_req;
    coord_x_t head_x;
    coord_y_t head_y;
    len_t     snake_len;
    idx_t     body_rd_addr;
    coord_x_t body_rd_x;
    coord_y_t body_rd_y;
    coord_x_t apple_x;
    coord_y_t apple_y;
    logic     apple_valid;
    logic     busy;
    logic     done;
    logic     eaten;
    logic     fail;

    modport master (
        output place_req, head_x, head_y, snake_len,
        output body_rd_x, body_rd_y,
        input  body_rd_addr,
        input  apple_x, apple_y, apple_valid,
        input  busy, done, eaten, fail
    );

    modport slave (
        input  place_req, head_x, head_y, snake_len,
        input  body_rd_x, body_rd_y,
        output body_rd_addr,
        output apple_x, apple_y, apple_valid,
        output busy, done, eaten, fail
    );

endinterface

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR; shifts left, feedback enters at bit 0.
module lfsr_gen #(
    parameter int           W    = 6,
    parameter logic [W-1:0] SEED = '1,
    parameter logic [W-1:0] TAPS = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic         w_fb;

    assign w_fb = ^(r_q & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[W-2:0], w_fb};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/apple_place_ctrl.sv
// Apple placement: draws LFSR candidates, rejects off-grid cells and
// scans every body segment before committing a free cell as the apple.
module apple_place_ctrl
    import snake_pkg::*;
#(
    parameter logic [7:0] MAX_TRIES = 8'd255,
    parameter coord_x_t   SEED_X    = 6'h2D,
    parameter coord_y_t   SEED_Y    = 5'h13
) (
    input logic               clk,
    input logic               rst_n,
    apple_place_ctrl_if.slave bus
);

    state_t     r_state;
    state_t     w_next;

    coord_x_t   w_lfsr_x;
    coord_y_t   w_lfsr_y;
    coord_x_t   r_cand_x;
    coord_y_t   r_cand_y;
    coord_x_t   r_apple_x;
    coord_y_t   r_apple_y;

    len_t       r_len;
    idx_t       r_idx;
    idx_t       w_addr;
    logic       r_prime;
    logic [7:0] r_tries;
    logic [7:0] w_tries_inc;

    logic       r_valid;
    logic       r_done;
    logic       r_eaten;
    logic       r_fail;

    logic       w_hit_apple;
    logic       w_in_grid;
    logic       w_seg_hit;
    logic       w_last;

    lfsr_gen #(
        .W    (XW),
        .SEED (SEED_X),
        .TAPS (TAPS_X)
    ) u_lfsr_x (
        .clk   (clk),
        .rst_n (rst_n),
        .o_q   (w_lfsr_x)
    );

    lfsr_gen #(
        .W    (YW),
        .SEED (SEED_Y),
        .TAPS (TAPS_Y)
    ) u_lfsr_y (
        .clk   (clk),
        .rst_n (rst_n),
        .o_q   (w_lfsr_y)
    );

    assign w_hit_apple = r_valid
                      && (bus.head_x == r_apple_x)
                      && (bus.head_y == r_apple_y);

    assign w_in_grid = (w_lfsr_x < X_LIM) && (w_lfsr_y < Y_LIM);

    // First SCAN cycle only primes the RAM; its read data is stale
    assign w_seg_hit = !r_prime
                    && (bus.body_rd_x == r_cand_x)
                    && (bus.body_rd_y == r_cand_y);

    assign w_last = r_prime ? (r_len == '0)
                            : ({1'b0, r_idx} == (r_len - 1'b1));

    assign w_tries_inc = r_tries + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_addr = '0;
        unique case (r_state)
            IDLE: begin
                if (w_hit_apple || bus.place_req) begin
                    w_next = DRAW;
                end
            end
            DRAW: begin
                if (w_in_grid) begin
                    w_next = SCAN;
                end else if (w_tries_inc == MAX_TRIES) begin
                    w_next = FAIL;
                end
            end
            SCAN: begin
                w_addr = r_prime ? '0 : r_idx + 1'b1;
                if (w_seg_hit) begin
                    w_next = (r_tries == MAX_TRIES) ? FAIL : DRAW;
                end else if (w_last) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: w_next = IDLE;
            FAIL:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_x  <= '0;
            r_cand_y  <= '0;
            r_apple_x <= '0;
            r_apple_y <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_prime   <= 1'b0;
            r_tries   <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_eaten   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_eaten <= 1'b0;
            r_fail  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_hit_apple) begin
                        r_eaten <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                DRAW: begin
                    r_cand_x <= w_lfsr_x;
                    r_cand_y <= w_lfsr_y;
                    r_tries  <= w_tries_inc;
                    r_len    <= bus.snake_len;
                    r_idx    <= '0;
                    r_prime  <= 1'b1;
                end
                SCAN: begin
                    r_prime <= 1'b0;
                    if (!r_prime) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                COMMIT: r_tries <= '0;
                FAIL:   r_tries <= '0;
                default: ;
            endcase
            // Pulses and the new apple appear during the COMMIT/FAIL cycle
            if (w_next == COMMIT) begin
                r_apple_x <= r_cand_x;
                r_apple_y <= r_cand_y;
                r_valid   <= 1'b1;
                r_done    <= 1'b1;
            end
            if (w_next == FAIL) begin
                r_fail <= 1'b1;
            end
        end
    end

    assign bus.body_rd_addr = w_addr;
    assign bus.apple_x      = r_apple_x;
    assign bus.apple_y      = r_apple_y;
    assign bus.apple_valid  = r_valid;
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_done;
    assign bus.eaten        = r_eaten;
    assign bus.fail         = r_fail;

endmodule

// File: tb/tb_apple_place_ctrl.sv
// Self-checking bench for apple_place_ctrl with a cycle-level reference
// model built from the LFSR sequences and the placement timing rules.
module tb_apple_place_ctrl;
    import snake_pkg::*;

    typedef struct {
        int len;
        int plant;
        bit echo;
        int exp_fail;
        bit poke;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc;
    int          checks = 0;
    int          errors = 0;
    logic [5:0]  xs [63];
    logic [4:0]  ys [31];
    logic [5:0]  seg_x [64];
    logic [4:0]  seg_y [64];
    bit          echo = 1'b0;
    bit          exp_valid = 1'b0;
    logic [21:0] w_outs;

    apple_place_ctrl_if bus();

    apple_place_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign w_outs = {bus.apple_x, bus.apple_y, bus.apple_valid,
                     bus.busy, bus.done, bus.eaten, bus.fail,
                     bus.body_rd_addr};

    // Body RAM: synchronous read, or echo of last cycle's LFSR pair
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            bus.body_rd_x <= '0;
            bus.body_rd_y <= '0;
        end else begin
            cyc <= cyc + 1;
            if (echo) begin
                bus.body_rd_x <= xs[(cyc + 62) % 63];
                bus.body_rd_y <= ys[(cyc + 30) % 31];
            end else begin
                bus.body_rd_x <= seg_x[bus.body_rd_addr];
                bus.body_rd_y <= seg_y[bus.body_rd_addr];
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] nx(input logic [5:0] v);
        return {v[4:0], v[5] ^ v[4]};
    endfunction

    function automatic logic [4:0] ny(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[2]};
    endfunction

    // Walks draws from cycle 'start'; returns cycle of done/fail pulse
    function automatic void predict(input int start, input int len,
                                    input bit ech, output int ev,
                                    output bit evf, output logic [5:0] ex,
                                    output logic [4:0] ey);
        int d = start;
        int tries = 0;
        bit fin = 1'b0;
        int hit;
        ev = 0;
        evf = 1'b0;
        ex = '0;
        ey = '0;
        while (!fin) begin
            if (tries == 255) begin
                ev = d;
                evf = 1'b1;
                fin = 1'b1;
            end else begin
                tries++;
                ex = xs[d % 63];
                ey = ys[d % 31];
                if (ex >= 40 || ey >= 30) begin
                    d++;
                end else begin
                    hit = -1;
                    if (ech && len > 0) hit = 0;
                    else
                        for (int j = 0; j < len; j++)
                            if (hit < 0 && seg_x[j] == ex && seg_y[j] == ey)
                                hit = j;
                    if (hit >= 0) d += hit + 3;
                    else begin
                        ev = d + len + 2;
                        fin = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_off;
        for (int j = 0; j < 64; j++) begin
            seg_x[j] = 6'(50 + j % 10);
            seg_y[j] = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic fill_rand;
        for (int j = 0; j < 64; j++) begin
            seg_x[j] = 6'($urandom_range(0, 39));
            seg_y[j] = 5'($urandom_range(0, 29));
        end
    endtask

    task automatic await_result(input string nm, input int start,
                                input int len, input bit ech,
                                input int exp_fail, input bit poke);
        int ev;
        bit evf;
        logic [5:0] ex;
        logic [4:0] ey;
        bit seen = 1'b0;
        bit free;
        predict(start, len, ech, ev, evf, ex, ey);
        for (int k = 0; k < 6000 && !seen; k++) begin
            if (bus.done || bus.fail) seen = 1'b1;
            else begin
                if (poke) bus.place_req = (k == 3);
                tick;
            end
        end
        bus.place_req = 1'b0;
        chk({nm, " result seen"}, 32'(seen), 1);
        if (seen) begin
            chk({nm, " cycle"}, cyc, ev);
            chk({nm, " fail flag"}, 32'(bus.fail), 32'(evf));
            if (exp_fail >= 0)
                chk({nm, " outcome"}, 32'(bus.fail), exp_fail);
            if (!evf) begin
                chk({nm, " apple_x"}, 32'(bus.apple_x), 32'(ex));
                chk({nm, " apple_y"}, 32'(bus.apple_y), 32'(ey));
                chk({nm, " valid"}, 32'(bus.apple_valid), 1);
                exp_valid = 1'b1;
                free = (bus.apple_x < 40) && (bus.apple_y < 30);
                for (int j = 0; j < len; j++)
                    if (seg_x[j] == bus.apple_x && seg_y[j] == bus.apple_y)
                        free = 1'b0;
                if (!ech) chk({nm, " free cell"}, 32'(free), 1);
            end else begin
                chk({nm, " valid after fail"}, 32'(bus.apple_valid),
                    32'(exp_valid));
            end
            tick;
            chk({nm, " back idle"},
                32'({bus.busy, bus.done, bus.fail}), 0);
            if (poke) begin
                repeat (3) tick;
                chk({nm, " busy req ignored"}, 32'(bus.busy), 0);
            end
        end
    endtask

    task automatic run(input string nm, input int len, input int plant,
                       input bit ech, input int exp_fail, input bit poke);
        int n;
        int d;
        bus.snake_len = 7'(len);
        echo = ech;
        n = cyc;
        if (plant >= 0) begin
            d = n + 1;
            while (xs[d % 63] >= 40 || ys[d % 31] >= 30) d++;
            seg_x[plant] = xs[d % 63];
            seg_y[plant] = ys[d % 31];
        end
        bus.place_req = 1'b1;
        tick;
        bus.place_req = 1'b0;
        await_result(nm, n + 1, len, ech, exp_fail, poke);
        if (plant >= 0 && !bus.fail)
            chk({nm, " two scans"}, 32'(cyc - 1 - (n + 1) >= 2 * (len + 1)), 1);
    endtask

    initial begin
        vec_t tv [6];
        int s57;
        bit found;
        int ev;
        bit evf;
        logic [5:0] ex;
        logic [4:0] ey;
        int n;
        bit reached;

        xs[0] = 6'h2D;
        ys[0] = 5'h13;
        for (int k = 1; k < 63; k++) xs[k] = nx(xs[k-1]);
        for (int k = 1; k < 31; k++) ys[k] = ny(ys[k-1]);

        tv[0] = '{1,  -1, 1'b1, 1, 1'b0};
        tv[1] = '{0,  -1, 1'b0, 0, 1'b0};
        tv[2] = '{4,   2, 1'b0, 0, 1'b0};
        tv[3] = '{1,   0, 1'b0, 0, 1'b0};
        tv[4] = '{64, 63, 1'b0, 0, 1'b0};
        tv[5] = '{64, -1, 1'b0, 0, 1'b1};

        bus.place_req = 1'b0;
        bus.head_x = 6'd63;
        bus.head_y = 5'd31;
        bus.snake_len = '0;
        fill_off();

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", 32'(w_outs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick;
            chk("idle outputs", 32'(w_outs), 0);
        end

        for (int i = 0; i < 6; i++) begin
            fill_off();
            run($sformatf("vec%0d", i), tv[i].len, tv[i].plant,
                tv[i].echo, tv[i].exp_fail, tv[i].poke);
        end

        for (int r = 0; r < 8; r++) begin
            fill_rand();
            repeat ($urandom_range(0, 20)) tick;
            run($sformatf("rand%0d", r), $urandom_range(0, 64), -1,
                1'b0, -1, 1'b0);
        end

        // Place the apple at (5,7), then steer the head onto it
        fill_off();
        found = 1'b0;
        s57 = 0;
        for (int s = cyc + 2; s < cyc + 2600 && !found; s++) begin
            predict(s, 0, 1'b0, ev, evf, ex, ey);
            if (!evf && ex == 6'd5 && ey == 5'd7) begin
                found = 1'b1;
                s57 = s;
            end
        end
        chk("find start for 5,7", 32'(found), 1);
        if (found) begin
            while (cyc < s57 - 1) tick;
            run("apple57", 0, -1, 1'b0, 0, 1'b0);
            chk("apple at 5,7", 32'({bus.apple_x, bus.apple_y}),
                32'({6'd5, 5'd7}));
            n = cyc;
            bus.head_x = 6'd5;
            bus.head_y = 5'd7;
            tick;
            bus.head_x = 6'd63;
            bus.head_y = 5'd31;
            chk("eaten pulse", 32'(bus.eaten), 1);
            chk("eaten clears valid", 32'(bus.apple_valid), 0);
            chk("eaten busy", 32'(bus.busy), 1);
            exp_valid = 1'b0;
            tick;
            chk("eaten one cycle", 32'(bus.eaten), 0);
            await_result("redraw", n + 1, 0, 1'b0, 0, 1'b0);
        end

        // Abort a placement mid-scan with reset
        fill_off();
        bus.snake_len = 7'd20;
        echo = 1'b0;
        bus.place_req = 1'b1;
        tick;
        bus.place_req = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 400 && !reached; k++) begin
            if (bus.busy && bus.body_rd_addr >= 3) reached = 1'b1;
            else tick;
        end
        chk("reached scan", 32'(reached), 1);
        rst_n = 1'b0;
        #1;
        chk("abort outputs", 32'(w_outs), 0);
        exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        run("after reset", 0, -1, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
